// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute over a shared memory port
// and a reused ALU, stalling memory states on mem_ready. Only the state and illegal flag are registered.
module multicycle_controller #(
  parameter int MEM_WAIT_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic [1:0] RegWriteSrc,
  output logic [3:0] ALUControl,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_AUIPC, S_TRAP
  } state_t;

  state_t state, state_nxt;
  logic   illegal_r;
  logic   rdy;

  assign rdy = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

  // funct7b5 selects sub only for R-type; for I-type it is an immediate bit (except srai).
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                            input logic is_rtype);
    logic [3:0] ctl;
    case (f3)
      3'b000:  ctl = (is_rtype && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  ctl = ALU_SLL;
      3'b010:  ctl = ALU_SLT;
      3'b011:  ctl = ALU_SLTU;
      3'b100:  ctl = ALU_XOR;
      3'b101:  ctl = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  ctl = ALU_OR;
      default: ctl = ALU_AND;
    endcase
    return ctl;
  endfunction

  function automatic logic insn_legal(input logic [6:0] opc, input logic [2:0] f3,
                                      input logic f7b5);
    logic ok;
    case (opc)
      OP_LOAD, OP_STORE:                  ok = (f3 == 3'b010);
      OP_BRANCH:                          ok = (f3 == 3'b000) || (f3 == 3'b001);
      OP_RTYPE:                           ok = !f7b5 || (f3 == 3'b000) || (f3 == 3'b101);
      OP_ITYPE, OP_JAL, OP_LUI, OP_AUIPC: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_FETCH;
      illegal_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE && state_nxt == S_TRAP) illegal_r <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    if (rdy) state_nxt = S_DECODE;
      S_DECODE: begin
        if (!insn_legal(op, funct3, funct7b5)) begin
          state_nxt = S_TRAP;
        end else begin
          case (op)
            OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
            OP_RTYPE:          state_nxt = S_EXECR;
            OP_ITYPE:          state_nxt = S_EXECI;
            OP_BRANCH:         state_nxt = S_BRANCH;
            OP_JAL:            state_nxt = S_JAL;
            OP_LUI:            state_nxt = S_LUI;
            OP_AUIPC:          state_nxt = S_AUIPC;
            default:           state_nxt = S_TRAP;
          endcase
        end
      end
      S_MEMADR:   state_nxt = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (rdy) state_nxt = S_MEMWB;
      S_MEMWRITE: if (rdy) state_nxt = S_FETCH;
      S_MEMWB, S_ALUWB, S_BRANCH, S_LUI:  state_nxt = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_AUIPC:   state_nxt = S_ALUWB;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Outputs are forced to defaults while reset is low so no write escapes an aborted instruction.
  always_comb begin
    PCWrite     = 1'b0;
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ImmSrc      = 3'b000;
    RegWrite    = 1'b0;
    RegWriteSrc = 2'b00;
    ALUControl  = ALU_ADD;
    illegal     = 1'b0;
    if (reset) begin
      illegal = illegal_r;
      case (state)
        S_FETCH: begin
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = rdy;
          PCWrite   = rdy;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          ImmSrc  = (op == OP_JAL) ? 3'b011 : 3'b010;
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ImmSrc  = (op == OP_LOAD) ? 3'b000 : 3'b001;
        end
        S_MEMREAD:  AdrSrc = 1'b1;
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXECR: begin
          ALUSrcA    = 2'b10;
          ALUControl = alu_decode(funct3, funct7b5, 1'b1);
        end
        S_EXECI: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = 2'b01;
          ALUControl = alu_decode(funct3, funct7b5, 1'b0);
        end
        S_ALUWB:    RegWrite = 1'b1;
        S_BRANCH: begin
          ALUSrcA    = 2'b10;
          ALUControl = ALU_SUB;
          PCWrite    = ((funct3 == 3'b000) && Zero) || ((funct3 == 3'b001) && !Zero);
        end
        S_JAL: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          PCWrite = 1'b1;
        end
        S_LUI: begin
          ImmSrc      = 3'b100;
          RegWriteSrc = 2'b01;
          RegWrite    = 1'b1;
        end
        S_AUIPC: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          ImmSrc  = 3'b100;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: an instruction-level model expands each
// instruction into its expected per-cycle control word and a compare process checks every cycle.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcw, adr, memw, irw;
    logic [1:0] res, srca, srcb;
    logic [2:0] imm;
    logic       regw;
    logic [1:0] rws;
    logic [3:0] aluc;
    logic       ill;
  } ctl_t;

  typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE, P_EXECR,
                P_EXECI, P_ALUWB, P_BRANCH, P_JAL, P_LUI, P_AUIPC, P_TRAP} phase_t;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011;
  localparam logic [6:0] ITYPE = 7'b0010011, BRANCH = 7'b1100011, JAL = 7'b1101111;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, SYSTEM = 7'b1110011;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, RegWriteSrc;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    n;
  ctl_t  exp_c;
  ctl_t  got;
  bit    exp_vld = 1'b0;
  string cur = "init";

  multicycle_controller #(.MEM_WAIT_EN(1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .RegWriteSrc(RegWriteSrc),
    .ALUControl(ALUControl), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
                RegWrite, RegWriteSrc, ALUControl, illegal};

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (exp_vld) begin
      tests = tests + 1;
      if (got !== exp_c) begin
        fails = fails + 1;
        $display("FAIL %s cyc=%0d: got %h required %h", cur, cyc, got, exp_c);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] alu_exp(input logic [2:0] f, input logic f7, input logic r);
    case (f)
      3'd0: return (r && f7) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return f7 ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic bit legal(input logic [6:0] o, input logic [2:0] f, input logic f7);
    if (o == LOAD || o == STORE) return f == 3'd2;
    if (o == BRANCH) return f == 3'd0 || f == 3'd1;
    if (o == RTYPE) return !f7 || f == 3'd0 || f == 3'd5;
    return o == ITYPE || o == JAL || o == LUI || o == AUIPC;
  endfunction

  function automatic ctl_t model(input phase_t p, input logic [6:0] o, input logic [2:0] f,
                                 input logic f7, input logic z, input logic rdy);
    ctl_t c;
    c = '0;
    case (p)
      P_FETCH:    begin c.srcb = 2; c.res = 2; c.irw = rdy; c.pcw = rdy; end
      P_DECODE:   begin c.srca = 1; c.srcb = 1; c.imm = (o == JAL) ? 3'd3 : 3'd2; end
      P_MEMADR:   begin c.srca = 2; c.srcb = 1; c.imm = (o == LOAD) ? 3'd0 : 3'd1; end
      P_MEMREAD:  c.adr = 1;
      P_MEMWB:    begin c.res = 1; c.regw = 1; end
      P_MEMWRITE: begin c.adr = 1; c.memw = 1; end
      P_EXECR:    begin c.srca = 2; c.aluc = alu_exp(f, f7, 1'b1); end
      P_EXECI:    begin c.srca = 2; c.srcb = 1; c.aluc = alu_exp(f, f7, 1'b0); end
      P_ALUWB:    c.regw = 1;
      P_BRANCH:   begin c.srca = 2; c.aluc = 1; c.pcw = (f == 0 && z) || (f == 1 && !z); end
      P_JAL:      begin c.srca = 1; c.srcb = 2; c.pcw = 1; end
      P_LUI:      begin c.imm = 4; c.rws = 1; c.regw = 1; end
      P_AUIPC:    begin c.srca = 1; c.srcb = 1; c.imm = 4; end
      P_TRAP:     c.ill = 1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  task automatic ph(input phase_t p, input logic rdy, input string nm);
    mem_ready = rdy;
    exp_c     = model(p, op, funct3, funct7b5, Zero, rdy);
    cur       = nm;
    exp_vld   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_cycles(input int k);
    reset = 1'b0;
    for (int i = 0; i < k; i++) begin
      mem_ready = 1'($urandom);
      exp_c     = '0;
      cur       = "reset";
      exp_vld   = 1'b1;
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [3:0] g, input logic [3:0] w);
    tests = tests + 1;
    if (g !== w) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d required %0d", nm, g, w);
    end
  endtask

  task automatic chk_int(input string nm, input int g, input int w);
    tests = tests + 1;
    if (g != w) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d required %0d", nm, g, w);
    end
  endtask

  // Expands one instruction into its cycle sequence; IR fields are garbage while fetching.
  task automatic instr(input string nm, input logic [6:0] o, input logic [2:0] f,
                       input logic f7, input logic z, input int fwait, input int mwait,
                       output int ncyc);
    ncyc = 0;
    Zero = z;
    for (int i = 0; i <= fwait; i++) begin
      op = 7'($urandom); funct3 = 3'($urandom); funct7b5 = 1'($urandom);
      ph(P_FETCH, (i == fwait), {nm, ".fetch"});
      ncyc++;
    end
    op = o; funct3 = f; funct7b5 = f7;
    ph(P_DECODE, 1'($urandom), {nm, ".decode"}); ncyc++;
    if (!legal(o, f, f7)) begin
      for (int i = 0; i < 3; i++) begin
        ph(P_TRAP, 1'($urandom), {nm, ".trap"}); ncyc++;
      end
      return;
    end
    case (o)
      LOAD, STORE: begin
        ph(P_MEMADR, 1'($urandom), {nm, ".memadr"}); ncyc++;
        for (int i = 0; i <= mwait; i++) begin
          ph((o == LOAD) ? P_MEMREAD : P_MEMWRITE, (i == mwait), {nm, ".mem"}); ncyc++;
        end
        if (o == LOAD) begin ph(P_MEMWB, 1'($urandom), {nm, ".memwb"}); ncyc++; end
      end
      RTYPE:  begin ph(P_EXECR, 1'($urandom), {nm, ".execr"}); ph(P_ALUWB, 1'($urandom), {nm, ".aluwb"}); ncyc += 2; end
      ITYPE:  begin ph(P_EXECI, 1'($urandom), {nm, ".execi"}); ph(P_ALUWB, 1'($urandom), {nm, ".aluwb"}); ncyc += 2; end
      BRANCH: begin ph(P_BRANCH, 1'($urandom), {nm, ".branch"}); ncyc++; end
      JAL:    begin ph(P_JAL, 1'($urandom), {nm, ".jal"}); ph(P_ALUWB, 1'($urandom), {nm, ".aluwb"}); ncyc += 2; end
      LUI:    begin ph(P_LUI, 1'($urandom), {nm, ".lui"}); ncyc++; end
      default: begin ph(P_AUIPC, 1'($urandom), {nm, ".auipc"}); ph(P_ALUWB, 1'($urandom), {nm, ".aluwb"}); ncyc += 2; end
    endcase
  endtask

  task automatic trap_case(input string nm, input logic [6:0] o, input logic [2:0] f,
                           input logic f7);
    int k;
    instr(nm, o, f, f7, 1'b0, 0, 0, k);
    chk({nm, "_illegal_set"}, {3'b0, illegal}, 4'd1);
    chk({nm, "_no_regwrite"}, {3'b0, RegWrite}, 4'd0);
    rst_cycles(1);
    mem_ready = 1'b0;
    #1;
    chk({nm, "_illegal_clr"}, {3'b0, illegal}, 4'd0);
  endtask

  initial begin
    #1;
    rst_cycles(2);

    instr("addi_f7", ITYPE, 3'd0, 1'b1, 1'b0, 0, 0, n);
    chk_int("cyc_addi", n, 4);

    // Abort a load while it waits in MEMREAD.
    Zero = 1'b0;
    op = 7'($urandom);
    ph(P_FETCH, 1'b1, "abort.fetch");
    op = LOAD; funct3 = 3'd2; funct7b5 = 1'b0;
    ph(P_DECODE, 1'b1, "abort.decode");
    ph(P_MEMADR, 1'b1, "abort.memadr");
    ph(P_MEMREAD, 1'b0, "abort.memread");
    rst_cycles(2);
    mem_ready = 1'b0;
    #1;
    chk("rst_illegal", {3'b0, illegal}, 4'd0);
    chk("rst_irwrite", {3'b0, IRWrite}, 4'd0);
    chk("rst_fetch_srcb", {2'b0, ALUSrcB}, 4'd2);

    instr("lw_wait3", LOAD, 3'd2, 1'b0, 1'b0, 0, 3, n);
    chk_int("cyc_lw_wait3", n, 8);
    instr("sub", RTYPE, 3'd0, 1'b1, 1'b0, 0, 0, n);
    chk_int("cyc_sub", n, 4);
    instr("sw_wait", STORE, 3'd2, 1'b0, 1'b0, 1, 2, n);
    chk_int("cyc_sw_wait", n, 7);
    instr("sw", STORE, 3'd2, 1'b0, 1'b0, 0, 0, n);
    chk_int("cyc_sw", n, 4);
    instr("bne_z0", BRANCH, 3'd1, 1'b0, 1'b0, 0, 0, n);
    chk_int("cyc_bne", n, 3);
    instr("beq_z0", BRANCH, 3'd0, 1'b0, 1'b0, 0, 0, n);
    chk_int("cyc_beq", n, 3);
    instr("beq_z1", BRANCH, 3'd0, 1'b0, 1'b1, 0, 0, n);
    instr("bne_z1", BRANCH, 3'd1, 1'b1, 1'b1, 0, 0, n);
    instr("lui", LUI, 3'd5, 1'b1, 1'b0, 0, 0, n);
    chk_int("cyc_lui", n, 3);
    instr("jal", JAL, 3'd3, 1'b0, 1'b0, 2, 0, n);
    chk_int("cyc_jal_fwait2", n, 6);
    instr("auipc", AUIPC, 3'd7, 1'b1, 1'b0, 0, 0, n);
    chk_int("cyc_auipc", n, 4);
    instr("srai", ITYPE, 3'd5, 1'b1, 1'b0, 0, 0, n);
    instr("srli", ITYPE, 3'd5, 1'b0, 1'b0, 0, 0, n);
    instr("sra", RTYPE, 3'd5, 1'b1, 1'b0, 0, 0, n);
    for (int f = 0; f < 8; f++) begin
      instr("rtype", RTYPE, 3'(f), 1'b0, 1'b0, 0, 0, n);
      instr("itype", ITYPE, 3'(f), 1'b0, 1'b0, 0, 0, n);
    end

    trap_case("ecall", SYSTEM, 3'd0, 1'b0);
    trap_case("lb", LOAD, 3'd0, 1'b0);
    trap_case("sh", STORE, 3'd1, 1'b0);
    trap_case("blt", BRANCH, 3'd4, 1'b0);
    trap_case("r_f7_sll", RTYPE, 3'd1, 1'b1);
    instr("add_after", RTYPE, 3'd0, 1'b0, 1'b0, 0, 0, n);
    chk_int("cyc_add_after", n, 4);

    exp_vld = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
